regfile_cc: RTL

- Parametrised general-purpose register file for the LC-3 datapath with integrated condition-code (NZP) generation, branch-enable (BEN) latch and a one-deep CC save/restore slot for interrupt entry and exit.
- Replaces the discrete 16-bit register, NZP and BEN blocks in the datapath.
- Provides two combinational read ports and one synchronous write port, with optional write-to-read bypass.

---
 rtl/regfile_cc.sv | 106 ++++++++++
 1 files changed

// File: rtl/regfile_cc.sv
// LC-3 general-purpose register file with NZP condition codes, branch-enable latch
// and a one-deep CC save slot used across interrupt entry and exit.
module regfile_cc #(
   parameter int WIDTH    = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter bit BYPASS   = 1'b0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              LD_REG,
   input  logic [ADDR_W-1:0] DR,
   input  logic [WIDTH-1:0]  D_in,
   input  logic [ADDR_W-1:0] SR1,
   input  logic [ADDR_W-1:0] SR2,
   output logic [WIDTH-1:0]  SR1_out,
   output logic [WIDTH-1:0]  SR2_out,
   input  logic              LD_CC,
   input  logic              LD_BEN,
   input  logic [2:0]        IR_nzp,
   input  logic              SAVE_CC,
   input  logic              RESTORE_CC,
   output logic [2:0]        CC_out,
   output logic              BEN
);

   localparam int                TABLE_DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   NUM_REGS_W  = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [2:0]        CC_ZERO     = 3'b010;

   logic [WIDTH-1:0] reg_array_reg [NUM_REGS];
   logic [WIDTH-1:0] rd_table [TABLE_DEPTH];
   logic [2:0]       cc_reg;
   logic [2:0]       save_reg;
   logic             ben_reg;
   logic [2:0]       cc_next;
   logic             dr_valid;
   logic             hit1;
   logic             hit2;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            reg_array_reg[i] <= '0;
         end
      end else if (LD_REG) begin
         // Out-of-range indices match no entry, so such writes simply drop.
         for (int i = 0; i < NUM_REGS; i++) begin
            if (DR == ADDR_W'(i)) begin
               reg_array_reg[i] <= D_in;
            end
         end
      end
   end

   // Pad the read view to the full index space so unused indices read as zero.
   generate
      for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_rd
         if (gi < NUM_REGS) begin : g_live
            assign rd_table[gi] = reg_array_reg[gi];
         end else begin : g_dead
            assign rd_table[gi] = '0;
         end
      end
   endgenerate

   assign dr_valid = ({1'b0, DR} < NUM_REGS_W);
   assign hit1     = BYPASS && LD_REG && dr_valid && (DR == SR1);
   assign hit2     = BYPASS && LD_REG && dr_valid && (DR == SR2);
   assign SR1_out  = hit1 ? D_in : rd_table[SR1];
   assign SR2_out  = hit2 ? D_in : rd_table[SR2];

   always_comb begin
      cc_next = 3'b001;
      if (D_in == '0) begin
         cc_next = CC_ZERO;
      end else if (D_in[WIDTH-1]) begin
         cc_next = 3'b100;
      end
   end

   // Save, restore and BEN all sample the pre-edge CC, which makes a swap fall out naturally.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cc_reg   <= CC_ZERO;
         save_reg <= CC_ZERO;
         ben_reg  <= 1'b0;
      end else begin
         if (RESTORE_CC) begin
            cc_reg <= save_reg;
         end else if (LD_CC) begin
            cc_reg <= cc_next;
         end
         if (SAVE_CC) begin
            save_reg <= cc_reg;
         end
         if (LD_BEN) begin
            ben_reg <= |(IR_nzp & cc_reg);
         end
      end
   end

   assign CC_out = cc_reg;
   assign BEN    = ben_reg;

endmodule
